// File: rtl/mainfsm_pkg.sv
// Shared types and constants for the multi-cycle main control FSM.
// Control bundle layout: {NextPC,Branch,MemW,RegW,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}.
package mainfsm_pkg;

  localparam int CTRL_W = 13;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_FAULT    = 4'd10,
    S_MULEX    = 4'd11
  } state_t;

  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       mem_w;
    logic       reg_w;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
  } ctrl_t;

  localparam logic [1:0] RS_ALU    = 2'b00;
  localparam logic [1:0] RS_MEM    = 2'b01;
  localparam logic [1:0] RS_ALUOUT = 2'b10;
  localparam logic [1:0] RS_MUL    = 2'b11;

  localparam ctrl_t C_FETCH    = 13'b1000_1_0_10_01_10_0;
  localparam ctrl_t C_DECODE   = 13'b0000_0_0_10_01_10_0;
  localparam ctrl_t C_EXECUTER = 13'b0000_0_0_00_00_00_1;
  localparam ctrl_t C_EXECUTEI = 13'b0000_0_0_00_00_01_1;
  localparam ctrl_t C_MULEX    = 13'b0000_0_0_00_00_00_0;
  localparam ctrl_t C_ALUWB    = 13'b0001_0_0_00_00_00_0;
  localparam ctrl_t C_MEMADR   = 13'b0000_0_0_00_00_01_0;
  localparam ctrl_t C_MEMRD    = 13'b0000_0_1_00_00_00_0;
  localparam ctrl_t C_MEMWR    = 13'b0010_0_1_00_00_00_0;
  localparam ctrl_t C_MEMWB    = 13'b0001_0_0_01_00_00_0;
  localparam ctrl_t C_BRANCH   = 13'b0100_0_0_10_00_01_0;
  localparam ctrl_t C_NONE     = 13'b0000_0_0_00_00_00_0;

  // States that hold a memory access open.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/fsm_wait_timer.sv
// Memory wait watchdog: counts not-ready cycles in a memory state.
// Clear has priority over increment; expire flags count == TIMEOUT.
module fsm_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] count;

  // Wait-cycle counter, cleared whenever the FSM changes state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

  assign expire = (count == LIMIT);

endmodule

// File: rtl/mainfsm_mc.sv
// Main control FSM for the multi-cycle datapath with memory wait
// handshake, watchdog fault state and a multi-cycle multiply state.
module mainfsm_mc
  import mainfsm_pkg::*;
#(
  parameter int WAIT_EN    = 1,
  parameter int TIMEOUT    = 15,
  parameter int MUL_EN     = 1,
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MulInstr,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       MemReq,
  output logic       MulStart,
  output logic       Fault,
  output logic [3:0] State
);

  localparam logic       WAIT_ON  = (WAIT_EN != 0);
  localparam logic       MUL_ON   = (MUL_EN != 0);
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] mul_cnt;
  logic       from_mul;
  logic       ready;
  logic       mem_req;
  logic       expire;
  logic       mul_start;
  ctrl_t      ctrl;
  logic       unused_funct;

  assign unused_funct = ^Funct[4:1];

  assign ready   = MemReady | ~WAIT_ON;
  assign mem_req = is_mem_state(state);

  fsm_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_nx != state),
    .inc    (mem_req & ~ready),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  // Multiply cycle counter; returns to zero on leaving MULEX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_cnt <= '0;
    end else if (state == S_MULEX && state_nx == S_MULEX) begin
      mul_cnt <= mul_cnt + 4'd1;
    end else begin
      mul_cnt <= '0;
    end
  end

  // Remembers that ALUWB was entered from MULEX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      from_mul <= 1'b0;
    end else begin
      from_mul <= (state == S_MULEX) && (state_nx == S_ALUWB);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = S_FETCH;
    unique case (state)
      S_FETCH: begin
        if (ready)       state_nx = S_DECODE;
        else if (expire) state_nx = S_FAULT;
        else             state_nx = S_FETCH;
      end
      S_DECODE: begin
        unique case (Op)
          2'b00: begin
            if (MulInstr && MUL_ON) state_nx = S_MULEX;
            else if (Funct[5])      state_nx = S_EXECUTEI;
            else                    state_nx = S_EXECUTER;
          end
          2'b01:   state_nx = S_MEMADR;
          2'b10:   state_nx = S_BRANCH;
          default: state_nx = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        state_nx = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        if (ready)       state_nx = S_MEMWB;
        else if (expire) state_nx = S_FAULT;
        else             state_nx = S_MEMRD;
      end
      S_MEMWR: begin
        if (ready)       state_nx = S_FETCH;
        else if (expire) state_nx = S_FAULT;
        else             state_nx = S_MEMWR;
      end
      S_EXECUTER: state_nx = S_ALUWB;
      S_EXECUTEI: state_nx = S_ALUWB;
      S_MULEX: begin
        state_nx = (mul_cnt == MUL_LAST) ? S_ALUWB : S_MULEX;
      end
      S_ALUWB:  state_nx = S_FETCH;
      S_MEMWB:  state_nx = S_FETCH;
      S_BRANCH: state_nx = S_FETCH;
      S_FAULT:  state_nx = S_FAULT;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Per-state control decode; illegal codes drive everything low.
  always_comb begin
    ctrl      = C_NONE;
    mul_start = 1'b0;
    unique case (state)
      S_FETCH: begin
        ctrl          = C_FETCH;
        ctrl.next_pc  = ready;
        ctrl.ir_write = ready;
      end
      S_DECODE:   ctrl = C_DECODE;
      S_MEMADR:   ctrl = C_MEMADR;
      S_MEMRD:    ctrl = C_MEMRD;
      S_MEMWB:    ctrl = C_MEMWB;
      S_MEMWR:    ctrl = C_MEMWR;
      S_EXECUTER: ctrl = C_EXECUTER;
      S_EXECUTEI: ctrl = C_EXECUTEI;
      S_ALUWB: begin
        ctrl = C_ALUWB;
        if (from_mul) ctrl.result_src = RS_MUL;
      end
      S_BRANCH: ctrl = C_BRANCH;
      S_FAULT:  ctrl = C_NONE;
      S_MULEX: begin
        ctrl      = C_MULEX;
        mul_start = (mul_cnt == 4'd0);
      end
      default: ctrl = C_NONE;
    endcase
  end

  assign NextPC    = ctrl.next_pc;
  assign Branch    = ctrl.branch;
  assign MemW      = ctrl.mem_w;
  assign RegW      = ctrl.reg_w;
  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign MemReq    = mem_req;
  assign MulStart  = mul_start;
  assign Fault     = (state == S_FAULT);
  assign State     = state;

endmodule

// File: doc/mainfsm_mc.md
Name: mainfsm_mc

Overview:
- Next-generation main control FSM for the multi-cycle ARM-subset datapath.
- Adds three things to the base FSM:
  - a memory ready/wait handshake with a watchdog timeout and sticky fault state;
  - a parametrised multi-cycle multiply execute state;
  - complete, deterministic decoding of all defined states (no X outputs).
- Sits in the controller beside the decoder, which still owns ALUControl, FlagW, PCS and condition logic.

Parameters:
- WAIT_EN, 1, 1 = honour MemReady; 0 = MemReady treated as constant 1 (zero-wait memory).
- TIMEOUT, 15, max wait cycles in a memory state before fault; range 1..255.
- MUL_EN, 1, 1 = MULEX path enabled; 0 = MulInstr ignored (decodes as EXECUTER).
- MUL_CYCLES, 4, cycles spent in MULEX; range 1..16.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- Op  in  2  instr[27:26]
- Funct  in  6  instr[25:20]
- MulInstr  in  1  decoder flag: Op=00, instr[7:4]=1001
- MemReady  in  1  memory completes current access this cycle
- IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp  out  1 each  datapath controls
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects
- MemReq  out  1  memory access request
- MulStart  out  1  one-cycle pulse on MULEX entry
- Fault  out  1  sticky watchdog fault
- State  out  4  current state, debug

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, FAULT=10, MULEX=11. Codes 12-15 are illegal and go to FETCH next cycle with all outputs 0.
- Reset: state=FETCH, wait counter=0, mul counter=0, Fault=0. Outputs follow FETCH decode immediately after reset, i.e. MemReq=1, but NextPC/IRWrite stay 0 until MemReady.
- Output bundle {NextPC,Branch,MemW,RegW,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp} per state:
  - FETCH 1000_1_0_10_01_10_0
  - DECODE 0000_0_0_10_01_10_0
  - EXECUTER 0000_0_0_00_00_00_1
  - EXECUTEI 0000_0_0_00_00_01_1
  - MULEX 0000_0_0_00_00_00_0
  - ALUWB 0001_0_0_00_00_00_0
  - MEMADR 0000_0_0_00_00_01_0
  - MEMRD 0000_0_1_00_00_00_0
  - MEMWR 0010_0_1_00_00_00_0
  - MEMWB 0001_0_0_01_00_00_0
  - BRANCH 0100_0_0_10_00_01_0
  - FAULT all 0
- ALUWB after MULEX uses ResultSrc=11 (multiplier result). Otherwise ALUWB uses 00.
- MemReq=1 in FETCH, MEMRD and MEMWR only.
- In FETCH, NextPC and IRWrite are ANDed with effective ready (MemReady | ~WAIT_EN). MemW is held for the whole of MEMWR.
- Transitions:
  - FETCH -> DECODE on ready, else stay.
  - DECODE, Op=00: MulInstr&MUL_EN -> MULEX; Funct[5] -> EXECUTEI; else -> EXECUTER.
  - DECODE, Op=01 -> MEMADR. Op=10 -> BRANCH. Op=11 -> FAULT.
  - MEMADR: Funct[0]=1 -> MEMRD; else -> MEMWR.
  - MEMRD -> MEMWB on ready. MEMWR -> FETCH on ready. Both stay otherwise.
  - EXECUTER/EXECUTEI -> ALUWB.
  - MULEX: stays until mul counter = MUL_CYCLES-1, then -> ALUWB. Counter clears on exit.
  - ALUWB, MEMWB, BRANCH -> FETCH.
  - FAULT: absorbing until reset.
- Wait counter (width 8):
  - Clears on every state change.
  - Increments each non-ready cycle in a MemReq state.
  - Not-ready while counter = TIMEOUT -> FAULT next cycle.
  - Ready in the same cycle as timeout: ready wins.
- Fault=1 exactly while in FAULT. Reset mid-wait or mid-multiply aborts immediately to FETCH.
- MulStart=1 only in the first MULEX cycle (mul counter=0).

Decomposition:
- Package mainfsm_pkg: state localparams, control-bundle width (13), per-state control constants, ResultSrc codes (ALU=00, MEM=01, ALUOUT=10, MUL=11).
- One sub-module, fsm_wait_timer: 8-bit counter with clear/inc/expire.

Test Plan:
- WAIT_EN=1, ADD reg (Op=00, Funct=000100), MemReady=1 always -> states 0,1,6,8,0. RegW=1 only in ALUWB cycle; NextPC high 1 cycle.
- LDR (Op=01, Funct=011001), MemReady low 3 cycles in MEMRD -> MEMRD held 4 cycles, MemReq=1 throughout, then MEMWB with ResultSrc=01, RegW=1.
- STR (Funct[0]=0), MemReady never high, TIMEOUT=15 -> FAULT entered after 16 MEMWR cycles. Fault stays 1 for 50 more cycles; reset returns to FETCH with Fault=0.
- MulInstr=1, MUL_CYCLES=4 -> MULEX for 4 cycles, MulStart on first only; ALUWB with ResultSrc=11. With MUL_EN=0 the same input yields EXECUTER.
- Branch (Op=10) -> 0,1,9,0 with Branch=1, ALUSrcB=01. Op=11 -> FAULT.
- Reset asserted mid-MULEX (cycle 2) -> State=0 asynchronously, counters 0, MulStart=0.
